// File: rtl/pc_seq_pkg.sv
// Shared widths, opcode/state encodings and jump-label defaults for the PC sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned LBL_N     = 16;
  localparam int unsigned LBL_IDX_W = 4;
  localparam int unsigned STK_DEPTH = 4;
  localparam int unsigned STK_IDX_W = 2;
  localparam int unsigned SP_W      = 3;

  typedef enum logic [2:0] {
    BR_NONE     = 3'd0,
    BR_JMP_ABS  = 3'd1,
    BR_JMP_LBL  = 3'd2,
    BR_Z        = 3'd3,
    BR_NZ       = 3'd4,
    BR_CALL_LBL = 3'd5,
    BR_RET      = 3'd6,
    BR_RSVD     = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] DEFAULT_LABELS [LBL_N] = '{
    16'd10, 16'd22, 16'd76, 16'd101, 16'd123, 16'd131, 16'd8,  16'd39,
    16'd18, 16'd46, 16'd83, 16'd60,  16'd0,   16'd0,   16'd0,  16'd0
  };

endpackage

// File: rtl/pc_sequencer_jump_label_table.sv
// Writable jump-label register file: reset loads defaults, one sync write, one comb read.
module jump_label_table
  import pc_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [LBL_IDX_W-1:0] wr_idx,
  input  logic [PC_W-1:0]      wr_data,
  input  logic [LBL_IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]      rd_data_c
);

  logic [PC_W-1:0] mem [LBL_N];

  // Reset reloads the default labels; otherwise apply the write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(LBL_N); i++) mem[i] <= DEFAULT_LABELS[i];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Same-cycle read sees the pre-write contents.
  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, label table, return stack and one-slot flush.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 advance,
  input  logic                 br_valid,
  input  logic [2:0]           br_op,
  input  logic [PC_W-1:0]      abs_target,
  input  logic [LBL_IDX_W-1:0] label_idx,
  input  logic                 zero_flag,
  input  logic                 lbl_wr_en,
  input  logic [LBL_IDX_W-1:0] lbl_wr_idx,
  input  logic [PC_W-1:0]      lbl_wr_data,
  output logic [PC_W-1:0]      pc,
  output logic                 pc_valid,
  output logic                 fault,
  output logic                 busy_flush
);

  state_e          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] lbl_target;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] stk_top;
  logic [PC_W-1:0] stack [STK_DEPTH];
  logic [SP_W-1:0] sp;
  logic            taken, fault_req, push, pop;
  logic            stk_full, stk_empty;
  br_op_e          op;

  jump_label_table u_lbl (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (lbl_wr_en),
    .wr_idx    (lbl_wr_idx),
    .wr_data   (lbl_wr_data),
    .rd_idx    (label_idx),
    .rd_data_c (lbl_target)
  );

  assign op        = br_op_e'(br_op);
  assign pc_inc    = pc + PC_W'(1);
  assign stk_full  = (sp == SP_W'(STK_DEPTH));
  assign stk_empty = (sp == '0);
  assign stk_top   = stack[STK_IDX_W'(sp - SP_W'(1))];

  // Next-state, next-PC and stack-operation decode.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    target    = pc;
    taken     = 1'b0;
    fault_req = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = '0;
        end
      end
      S_RUN: begin
        if (br_valid) begin
          case (op)
            BR_JMP_ABS: begin taken = 1'b1; target = abs_target; end
            BR_JMP_LBL: begin taken = 1'b1; target = lbl_target; end
            BR_Z:       begin taken = zero_flag;  target = lbl_target; end
            BR_NZ:      begin taken = !zero_flag; target = lbl_target; end
            BR_CALL_LBL: begin
              if (stk_full) fault_req = 1'b1;
              else begin taken = 1'b1; push = 1'b1; target = lbl_target; end
            end
            BR_RET: begin
              if (stk_empty) fault_req = 1'b1;
              else begin taken = 1'b1; pop = 1'b1; target = stk_top; end
            end
            default: ;
          endcase
        end
        if (fault_req) begin
          state_n = S_FAULT;
        end else if (taken) begin
          state_n = S_FLUSH;
          pc_n    = target;
        end else if (advance) begin
          pc_n = pc_inc;
        end
      end
      S_FLUSH: state_n = S_RUN;
      default: ;
    endcase
  end

  // State, PC, stack pointer and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      sp         <= '0;
      pc_valid   <= 1'b0;
      fault      <= 1'b0;
      busy_flush <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp - SP_W'(1);
      pc_valid   <= (state_n == S_RUN);
      fault      <= (state_n == S_FAULT);
      busy_flush <= (state_n == S_FLUSH);
    end
  end

  // Return-address storage; contents beyond sp are don't-care.
  always_ff @(posedge clk) begin
    if (!reset && push) stack[STK_IDX_W'(sp)] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset, start, advance, br_valid, zero_flag, lbl_wr_en;
  logic [2:0]  br_op;
  logic [15:0] abs_target, lbl_wr_data, pc;
  logic [3:0]  label_idx, lbl_wr_idx;
  logic        pc_valid, fault, busy_flush;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .advance(advance),
    .br_valid(br_valid), .br_op(br_op), .abs_target(abs_target),
    .label_idx(label_idx), .zero_flag(zero_flag), .lbl_wr_en(lbl_wr_en),
    .lbl_wr_idx(lbl_wr_idx), .lbl_wr_data(lbl_wr_data), .pc(pc),
    .pc_valid(pc_valid), .fault(fault), .busy_flush(busy_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_FAULT = 3;
  localparam int unsigned DEF_LBL [16] = '{10, 22, 76, 101, 123, 131, 8, 39,
                                           18, 46, 83, 60, 0, 0, 0, 0};

  int          n_chk = 0;
  int          n_bad = 0;
  int          m_st;
  int unsigned m_pc;
  int unsigned m_lbl [16];
  int unsigned m_stk [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: advance one clock using the currently driven inputs.
  task automatic model_step();
    int unsigned lv, tgt;
    bit taken, flt;
    lv = m_lbl[label_idx];
    taken = 0; flt = 0; tgt = 0;
    if (reset) begin
      m_st = M_IDLE; m_pc = 0; m_stk.delete();
      for (int i = 0; i < 16; i++) m_lbl[i] = DEF_LBL[i];
      return;
    end
    case (m_st)
      M_IDLE: if (start) begin m_st = M_RUN; m_pc = 0; end
      M_RUN: begin
        if (br_valid) begin
          case (int'(br_op))
            1: begin taken = 1; tgt = abs_target; end
            2: begin taken = 1; tgt = lv; end
            3: begin taken = zero_flag;  tgt = lv; end
            4: begin taken = !zero_flag; tgt = lv; end
            5: if (m_stk.size() >= 4) flt = 1;
               else begin m_stk.push_back((m_pc + 1) % 65536); taken = 1; tgt = lv; end
            6: if (m_stk.size() == 0) flt = 1;
               else begin tgt = m_stk.pop_back(); taken = 1; end
            default: ;
          endcase
        end
        if (flt) m_st = M_FAULT;
        else if (taken) begin m_st = M_FLUSH; m_pc = tgt; end
        else if (advance) m_pc = (m_pc + 1) % 65536;
      end
      M_FLUSH: m_st = M_RUN;
      default: ;
    endcase
    if (lbl_wr_en) m_lbl[lbl_wr_idx] = lbl_wr_data;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", 32'(pc), m_pc);
    chk("pc_valid", 32'(pc_valid), 32'(m_st == M_RUN));
    chk("fault", 32'(fault), 32'(m_st == M_FAULT));
    chk("busy_flush", 32'(busy_flush), 32'(m_st == M_FLUSH));
  endtask

  task automatic idle_in();
    reset = 0; start = 0; advance = 0; br_valid = 0; br_op = 0; abs_target = 0;
    label_idx = 0; zero_flag = 0; lbl_wr_en = 0; lbl_wr_idx = 0; lbl_wr_data = 0;
  endtask

  task automatic req(input logic [2:0] op, input logic [3:0] idx, input logic [15:0] abs_t,
                     input logic zf, input logic adv);
    br_valid = 1; br_op = op; label_idx = idx; abs_target = abs_t;
    zero_flag = zf; advance = adv;
    step();
    idle_in();
  endtask

  task automatic do_reset();
    idle_in(); reset = 1; step(); reset = 0;
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
  endtask

  task automatic jump_abs(input logic [15:0] t);
    req(3'd1, 4'd0, t, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    idle_in();
    do_reset();
    chk("reset_pc", 32'(pc), 0);
    chk("reset_valid", 32'(pc_valid), 0);
    // IDLE ignores advance and branches
    advance = 1; br_valid = 1; br_op = 3'd1; abs_target = 16'h55; step(); idle_in();
    do_start();
    chk("start_valid", 32'(pc_valid), 1);
    advance = 1; repeat (3) step();
    chk("adv_pc3", 32'(pc), 3);
    repeat (2) step();
    idle_in();
    // JMP_LBL with advance: branch wins, one flush cycle
    req(3'd2, 4'd3, 16'h0, 1'b0, 1'b1);
    chk("jl_flush", 32'(busy_flush), 1);
    chk("jl_flush_valid", 32'(pc_valid), 0);
    step();
    chk("jl_pc", 32'(pc), 101);
    chk("jl_valid", 32'(pc_valid), 1);
    // BR_Z untaken / taken
    jump_abs(16'd9);
    req(3'd3, 4'd7, 16'h0, 1'b0, 1'b1);
    chk("brz_untaken_pc", 32'(pc), 10);
    chk("brz_untaken_flush", 32'(busy_flush), 0);
    jump_abs(16'd9);
    req(3'd3, 4'd7, 16'h0, 1'b1, 1'b1);
    step();
    chk("brz_taken_pc", 32'(pc), 39);
    // NONE and reserved opcodes let advance through
    req(3'd0, 4'd0, 16'h0, 1'b0, 1'b1);
    req(3'd7, 4'd0, 16'h0, 1'b0, 1'b1);
    chk("none_rsvd_pc", 32'(pc), 41);
    // CALL / RET
    jump_abs(16'd20);
    req(3'd5, 4'd8, 16'h0, 1'b0, 1'b0); step();
    chk("call_pc", 32'(pc), 18);
    advance = 1; step(); step(); idle_in();
    req(3'd6, 4'd0, 16'h0, 1'b0, 1'b0); step();
    chk("ret_pc", 32'(pc), 21);
    // Nested calls overflow on the fifth
    for (int i = 0; i < 4; i++) begin req(3'd5, 4'd0, 16'h0, 1'b0, 1'b0); step(); end
    req(3'd5, 4'd1, 16'h0, 1'b0, 1'b0);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_valid", 32'(pc_valid), 0);
    chk("ovf_pc", 32'(pc), 10);
    lbl_wr_en = 1; lbl_wr_idx = 4'd11; lbl_wr_data = 16'hBEEF; advance = 1; step(); idle_in();
    step();
    do_reset();
    chk("reset_clears_fault", 32'(fault), 0);
    // RET on empty stack
    do_start();
    req(3'd6, 4'd0, 16'h0, 1'b0, 1'b1);
    chk("unf_fault", 32'(fault), 1);
    step();
    do_reset();
    do_start();
    // Label write races with a same-cycle read
    lbl_wr_en = 1; lbl_wr_idx = 4'd2; lbl_wr_data = 16'h1234;
    req(3'd2, 4'd2, 16'h0, 1'b0, 1'b0); step();
    chk("lbl_old", 32'(pc), 76);
    req(3'd2, 4'd2, 16'h0, 1'b0, 1'b0); step();
    chk("lbl_new", 32'(pc), 32'h1234);
    // PC wrap
    jump_abs(16'hFFFF);
    advance = 1; step(); idle_in();
    chk("wrap_pc", 32'(pc), 0);
    // Reset during flush restores defaults
    req(3'd1, 4'd0, 16'h4444, 1'b0, 1'b0);
    do_reset();
    chk("rst_flush_pc", 32'(pc), 0);
    chk("rst_flush_bf", 32'(busy_flush), 0);
    do_start();
    req(3'd2, 4'd2, 16'h0, 1'b0, 1'b0); step();
    chk("rst_lbl_default", 32'(pc), 76);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom % 64) == 0;
      start       = ($urandom % 4) == 0;
      advance     = 1'($urandom);
      br_valid    = ($urandom % 3) == 0;
      br_op       = 3'($urandom);
      abs_target  = 16'($urandom);
      label_idx   = 4'($urandom);
      zero_flag   = 1'($urandom);
      lbl_wr_en   = ($urandom % 8) == 0;
      lbl_wr_idx  = 4'($urandom);
      lbl_wr_data = 16'($urandom);
      step();
    end
    idle_in();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
